// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format (data bits, parity, stop bits)
// feeding a show-ahead receive FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned DEPTH        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx,
   output logic [DATA_BITS-1:0]     rx_data,
   output logic                     rx_perr,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic                     frame_err,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BW = 4;
   localparam int unsigned EW = DATA_BITS + 1;

   localparam logic [TW-1:0] HALF_T    = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] FULL_T    = TW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             sync_q;
   logic [TW-1:0]          tmr_q, tmr_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   perr_q, perr_d;
   logic                   serr_q, serr_d;
   logic                   ferr_q, ovf_q;
   logic                   rxs, tick_c, push_c, ferr_c;

   logic [EW-1:0]          mem_q [DEPTH];
   logic [AW-1:0]          wr_q, rd_q;
   logic [CW-1:0]          count_q;
   logic                   pop_c, full_c, wr_c, ovf_c;
   logic [EW-1:0]          head_c;

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (!rst) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], rx};
   end

   assign rxs    = sync_q[1];
   assign tick_c = (tmr_q == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
         ferr_q  <= ferr_c;
      end
   end

   // Frame sequencer: every sample is taken when the bit timer reaches zero
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      serr_d  = serr_q;
      push_c  = 1'b0;
      ferr_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxs) begin
               tmr_d   = HALF_T;
               state_d = S_START;
            end
         end
         S_START: begin
            if (!tick_c) tmr_d = tmr_q - TW'(1);
            else if (rxs) state_d = S_IDLE;
            else begin
               tmr_d   = FULL_T;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (!tick_c) tmr_d = tmr_q - TW'(1);
            else begin
               tmr_d   = FULL_T;
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  perr_d  = 1'b0;
                  serr_d  = 1'b0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         S_PARITY: begin
            if (!tick_c) tmr_d = tmr_q - TW'(1);
            else begin
               tmr_d   = FULL_T;
               perr_d  = (PARITY == 1) ? ~(^{shift_q, rxs}) : (^{shift_q, rxs});
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (!tick_c) tmr_d = tmr_q - TW'(1);
            else begin
               tmr_d = FULL_T;
               if (bit_q == LAST_STOP) begin
                  if (serr_q || !rxs) begin
                     ferr_c  = 1'b1;
                     state_d = S_BREAK;
                  end else begin
                     push_c  = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  serr_d = serr_q | ~rxs;
                  bit_d  = bit_q + BW'(1);
               end
            end
         end
         S_BREAK: begin
            if (rxs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Show-ahead FIFO; a pop frees the slot a same-cycle push into a full FIFO uses
   assign rx_valid = (count_q != '0);
   assign full_c   = (count_q == DEPTH_C);
   assign pop_c    = rx_valid & rx_ready;
   assign wr_c     = push_c & (~full_c | pop_c);
   assign ovf_c    = push_c & full_c & ~pop_c;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr_c) begin
            mem_q[wr_q] <= {perr_q, shift_q};
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_c) rd_q <= rd_q + AW'(1);
         count_q <= count_q + CW'(wr_c) - CW'(pop_c);
         ovf_q   <= ovf_c;
      end
   end

   assign head_c    = mem_q[rd_q];
   assign rx_data   = head_c[DATA_BITS-1:0];
   assign rx_perr   = head_c[DATA_BITS];
   assign frame_err = ferr_q;
   assign overflow  = ovf_q;
   assign count     = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance (DEPTH 4) and a 7E1 instance,
// both at 16 clocks per bit, checked against hand-computed frames.
module tb_uart_rx_fifo;

   localparam int unsigned C = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_a, rx_b, rdy_a, rdy_b;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       perr_a, perr_b, val_a, val_b, fe_a, fe_b, ovf_a, ovf_b;
   logic [2:0] cnt_a, cnt_b;

   int n_checks = 0;
   int n_fail   = 0;
   int fe_cnt_a = 0, fe_cnt_b = 0, ovf_cnt_a = 0, ovf_cnt_b = 0, vcnt_a = 0;
   logic val_a_prev = 1'b0;
   longint rise_a = 0, t_start_a = 0;
   logic [8:0] pop_a [$];
   logic [7:0] pop_b [$];

   uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_perr(perr_a), .rx_valid(val_a),
      .rx_ready(rdy_a), .frame_err(fe_a), .overflow(ovf_a), .count(cnt_a));

   uart_rx_fifo #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_perr(perr_b), .rx_valid(val_b),
      .rx_ready(rdy_b), .frame_err(fe_b), .overflow(ovf_b), .count(cnt_b));

   always #5 clk = ~clk;

   // Observe pulses and pops half a cycle away from the active edge
   always @(negedge clk) begin
      if (fe_a)  fe_cnt_a++;
      if (fe_b)  fe_cnt_b++;
      if (ovf_a) ovf_cnt_a++;
      if (ovf_b) ovf_cnt_b++;
      if (val_a) vcnt_a++;
      if (val_a && !val_a_prev) rise_a = $time;
      val_a_prev = val_a;
      if (val_a && rdy_a) pop_a.push_back({perr_a, data_a});
      if (val_b && rdy_b) pop_b.push_back({perr_b, data_b});
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int unsigned port, input logic v);
      if (port == 0) rx_a = v;
      else           rx_b = v;
   endtask

   task automatic send(input int unsigned port, input logic [8:0] data, input int unsigned nbits,
                       input logic use_par, input logic par_bit, input logic stop_val);
      if (port == 0) t_start_a = $time;
      set_rx(port, 1'b0);
      tick(C);
      for (int i = 0; i < int'(nbits); i++) begin
         set_rx(port, data[i]);
         tick(C);
      end
      if (use_par) begin
         set_rx(port, par_bit);
         tick(C);
      end
      set_rx(port, stop_val);
      tick(C);
   endtask

   task automatic send_a(input logic [7:0] d);
      send(0, {1'b0, d}, 8, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int fe0, ov0, vc0, np;
      longint t_first;

      rst = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
      tick(3);
      check_eq("reset_valid", 32'(val_a), 32'd0);
      check_eq("reset_count", 32'(cnt_a), 32'd0);
      check_eq("reset_ferr",  32'(fe_a),  32'd0);
      check_eq("reset_ovf",   32'(ovf_a), 32'd0);
      check_eq("reset_data",  32'(data_a), 32'd0);
      check_eq("reset_perr",  32'(perr_a), 32'd0);
      check_eq("reset_valid_b", 32'(val_b), 32'd0);
      rst = 1'b1;
      tick(5);

      // Back-to-back 8N1 frames drained immediately
      rdy_a = 1'b1;
      vc0 = vcnt_a;
      send_a(8'h55);
      send_a(8'hA3);
      tick(20);
      check_eq("basic_npop", 32'(pop_a.size()), 32'd2);
      check_eq("basic_b0", 32'(pop_a[0]), 32'h055);
      check_eq("basic_b1", 32'(pop_a[1]), 32'h0A3);
      check_eq("basic_valid_cycles", 32'(vcnt_a - vc0), 32'd2);
      check_eq("basic_flags", 32'(fe_cnt_a + ovf_cnt_a), 32'd0);
      check_eq("basic_count", 32'(cnt_a), 32'd0);

      // 7E1: 0x41 has two ones, so the even parity bit is 0
      rdy_b = 1'b1;
      send(1, 9'h041, 7, 1'b1, 1'b0, 1'b1);
      send(1, 9'h041, 7, 1'b1, 1'b1, 1'b1);
      tick(20);
      check_eq("par_npop", 32'(pop_b.size()), 32'd2);
      check_eq("par_good", 32'(pop_b[0]), 32'h41);
      check_eq("par_bad",  32'(pop_b[1]), 32'hC1);
      check_eq("par_ferr", 32'(fe_cnt_b), 32'd0);

      // Bad stop bit followed by a long break
      fe0 = fe_cnt_a; np = pop_a.size();
      send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
      tick(40 * C);
      rx_a = 1'b1;
      tick(2 * C);
      check_eq("break_ferr_once", 32'(fe_cnt_a - fe0), 32'd1);
      check_eq("break_count", 32'(cnt_a), 32'd0);
      check_eq("break_nopush", 32'(pop_a.size() - np), 32'd0);
      send_a(8'h12);
      tick(20);
      check_eq("after_break_npop", 32'(pop_a.size() - np), 32'd1);
      check_eq("after_break_data", 32'(pop_a[np]), 32'h012);

      // Three-clock glitch in idle
      fe0 = fe_cnt_a; ov0 = ovf_cnt_a; np = pop_a.size();
      rx_a = 1'b0;
      tick(3);
      rx_a = 1'b1;
      tick(3 * C);
      check_eq("glitch_nopush", 32'(pop_a.size() - np), 32'd0);
      check_eq("glitch_count", 32'(cnt_a), 32'd0);
      check_eq("glitch_flags", 32'((fe_cnt_a - fe0) + (ovf_cnt_a - ov0)), 32'd0);

      // Overflow: five frames into a four-entry FIFO with no consumer
      rdy_a = 1'b0;
      fe0 = fe_cnt_a; ov0 = ovf_cnt_a; t_first = 0;
      for (int i = 1; i <= 5; i++) begin
         send_a(8'(i));
         if (i == 1) t_first = t_start_a;
      end
      tick(20);
      check_eq("ovf_latency", 32'(rise_a - t_first), 32'd1554);
      check_eq("ovf_count", 32'(cnt_a), 32'd4);
      check_eq("ovf_pulses", 32'(ovf_cnt_a - ov0), 32'd1);
      check_eq("ovf_ferr", 32'(fe_cnt_a - fe0), 32'd0);
      np = pop_a.size();
      rdy_a = 1'b1;
      tick(8);
      rdy_a = 1'b0;
      check_eq("ovf_drain_n", 32'(pop_a.size() - np), 32'd4);
      for (int i = 0; i < 4; i++) check_eq("ovf_drain_data", 32'(pop_a[np + i]), 32'(i + 1));
      check_eq("ovf_drain_count", 32'(cnt_a), 32'd0);

      // Fifth push coincides with a pop while full
      ov0 = ovf_cnt_a;
      for (int i = 1; i <= 4; i++) send_a(8'(i));
      np = pop_a.size();
      fork
         send_a(8'h05);
         begin
            tick(154);
            rdy_a = 1'b1;
            tick(1);
            rdy_a = 1'b0;
         end
      join
      tick(20);
      check_eq("full_pop_count", 32'(cnt_a), 32'd4);
      check_eq("full_pop_ovf", 32'(ovf_cnt_a - ov0), 32'd0);
      check_eq("full_pop_n", 32'(pop_a.size() - np), 32'd1);
      check_eq("full_pop_head", 32'(pop_a[np]), 32'h001);
      rdy_a = 1'b1;
      tick(8);
      check_eq("full_pop_drain_n", 32'(pop_a.size() - np), 32'd5);
      for (int i = 1; i < 5; i++) check_eq("full_pop_drain", 32'(pop_a[np + i]), 32'(i + 1));

      // Reset during data bit 3 of 0xFF
      fe0 = fe_cnt_a; ov0 = ovf_cnt_a; np = pop_a.size();
      fork
         send_a(8'hFF);
         begin
            tick(70);
            rst = 1'b0;
            tick(1);
            rst = 1'b1;
         end
      join
      tick(20);
      send_a(8'h80);
      tick(20);
      check_eq("rst_mid_npop", 32'(pop_a.size() - np), 32'd1);
      check_eq("rst_mid_data", 32'(pop_a[np]), 32'h080);
      check_eq("rst_mid_flags", 32'((fe_cnt_a - fe0) + (ovf_cnt_a - ov0)), 32'd0);
      check_eq("rst_mid_count", 32'(cnt_a), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with configurable frame format, error flags and a receive FIFO. It is the synthesizable successor to the fixed 8N1, 115200 bps receive path the SoC uses on its `rx` pin. It sits between the external `rx` pin and the CPU's memory-mapped UART registers. It buffers bytes so firmware can drain them with a valid/ready handshake.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit; 868 gives 115200 bps at 100 MHz; minimum 4.
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `DEPTH`, 16: FIFO entries, a power of two, 2..256.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-low reset.
- `rx`, in, 1: asynchronous serial input; idles high.
- `rx_data`, out, DATA_BITS: data of the FIFO head entry.
- `rx_perr`, out, 1: parity-error flag stored with the head entry.
- `rx_valid`, out, 1: FIFO non-empty; head entry is valid.
- `rx_ready`, in, 1: consumer accepts the head entry; a pop occurs on `rx_valid && rx_ready`.
- `frame_err`, out, 1: one-cycle pulse when a stop bit is sampled low.
- `overflow`, out, 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `count`, out, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- `rx` passes through a 2-flop synchronizer, reset to 1. All logic below uses the synchronized value `rxs`.
- FSM states and transitions:
  - IDLE: waits for a falling edge of `rxs`, then loads the bit counter with CLKS_PER_BIT/2 and enters START.
  - START: at mid-bit, if `rxs`=1 the edge was a glitch and the FSM returns to IDLE with no flags. Otherwise it enters DATA.
  - DATA: samples DATA_BITS bits, each at mid-bit, one every CLKS_PER_BIT clocks, into a shift register LSB-first.
  - PARITY: entered only when PARITY≠0. Samples one bit. Error if the XOR of data and parity bit is 0 in odd mode, or 1 in even mode.
  - STOP: samples STOP_BITS bits.
    - All stop bits high: push {perr, data} into the FIFO, then go to IDLE.
    - Any stop bit low: pulse `frame_err`, push nothing, then go to BREAK.
  - BREAK: waits for `rxs`=1, then goes to IDLE. A held-low line produces exactly one `frame_err`.
- The FIFO is show-ahead. `rx_data` and `rx_perr` are valid whenever `rx_valid`=1, and are don't-care otherwise.
- Full FIFO at push time: the frame is dropped and `overflow` pulses. FIFO contents are unchanged.
- Push and pop in the same cycle: the pop is applied first. A push while full with a simultaneous pop is accepted, and `count` stays DEPTH.
- Pointers wrap modulo DEPTH. Full and empty are derived from `count`; `count` never exceeds DEPTH.
- Reset while a frame is in progress: the FSM goes to IDLE, FIFO pointers and `count` go to 0, and the partial frame is discarded.
  - If `rx` is still low after reset, there is no falling edge, so the rest of the frame is ignored.

## Timing
- Reset values:
  - `rx_valid`, `frame_err`, `overflow`: 0.
  - `count`: 0.
  - `rx_data`, `rx_perr`: 0.
  - FSM in IDLE; synchronizer flops at 1.
- Define T0 as the first cycle in which `rxs`=0 in IDLE, i.e. 2 clocks after the `rx` pin falls. The start sample occurs at T0 + CLKS_PER_BIT/2.
- Data bit k is sampled at T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Let N = 1 + DATA_BITS + (PARITY≠0). The final stop sample occurs at T0 + CLKS_PER_BIT/2 + (N+STOP_BITS−1)·CLKS_PER_BIT.
- The push, or the `frame_err`/`overflow` pulse, happens on the clock edge after the final stop sample.
- `rx_valid` rises 1 clock after the push into an empty FIFO.
- The FSM is back in IDLE in time to detect a start bit that begins immediately after the stop bit, so back-to-back frames are received with no gap.
- A pop takes effect on the same edge: `rx_data` shows the next entry, or `rx_valid` falls, in the following cycle.

## Test plan
- Basic receive (CLKS_PER_BIT=16, 8N1): send 0x55, then 0xA3 back-to-back, with `rx_ready`=1. Required: `rx_data` 0x55, then 0xA3, each with `rx_valid` high for 1 cycle, `rx_perr`=0, and no flags.
- Parity (7 data bits, PARITY=2): send 0x41 with correct parity, then 0x41 with inverted parity. Required: two entries, first with `rx_perr`=0, second with `rx_perr`=1; `frame_err`=0 throughout.
- Framing and break: send 0x3C with the stop bit low, then hold `rx` low for 40 bit times. Required: exactly one `frame_err` pulse, `count`=0, and a following 0x12 frame received correctly.
- Glitch: drive `rx` low for 3 clocks in IDLE. Required: no push, no flags, FSM back in IDLE.
- Overflow (DEPTH=4, `rx_ready`=0): send 0x01..0x05. Required: `count`=4, one `overflow` pulse on the fifth frame, then pops return 0x01..0x04.
  - Repeat with a pop coinciding with the fifth push. Required: 0x05 is accepted and `count` stays 4.
- Reset mid-frame: assert `rst`=0 for 1 cycle during data bit 3 of 0xFF, then send 0x80. Required: only 0x80 is received and no flags are raised.
